// File: rtl/fifo_drain_arb_pkg.sv
// Shared definitions for the FIFO drain arbiter: FSM state encoding and the
// width helper used to size the channel index and burst counter.
package fifo_drain_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_BURST = ST_BURST
    } state_e;

    // Bits needed to index 'value' items, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: returns the first set request bit strictly after ptr,
// wrapping modulo NUM_CH. ptr itself is checked last, so the previous winner
// has the lowest priority but is still chosen when it is the only requester.
module fifo_rr_pick
    import fifo_drain_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              any,
    output logic [CH_W-1:0]   idx
);

    int              cand;
    logic [CH_W-1:0] cand_w;

    // Walk the ring from farthest to nearest so the nearest request wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        any    = |req;
        idx    = '0;
        cand   = 0;
        cand_w = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            cand_w = CH_W'(cand);
            if (req[cand_w]) idx = cand_w;
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin read-side arbiter for NUM_CH first-word-fall-through FIFOs.
// Grants one channel at a time, drains up to MAX_BURST words from it onto a
// single valid/ready stream tagged with the channel number, and leaves one
// IDLE bubble between grants. Output data is taken straight from the FIFO head.
// Optional per-channel accepted-word counters: define DRAIN_ARB_STATS_EN.
module fifo_drain_arbiter
    import fifo_drain_arb_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BURST  = 8,
    localparam int CH_W       = clog2(NUM_CH),
    localparam int BC_W       = clog2(MAX_BURST)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_rd_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_dat,
    output logic [NUM_CH-1:0]            ch_rd_ena,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_dat,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    output logic                         busy
`ifdef DRAIN_ARB_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [NUM_CH*32-1:0]         stat_words
`endif
);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       gnt_q, gnt_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       bcnt_q, bcnt_d;

    logic [NUM_CH-1:0]     req;
    logic                  pick_any;
    logic [CH_W-1:0]       pick_idx;
    logic [DATA_WIDTH-1:0] head_dat [NUM_CH];
    logic                  gnt_empty;
    logic                  hs;

    assign req       = ~ch_rd_empty;
    assign gnt_empty = ch_rd_empty[gnt_q];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_head
        assign head_dat[i] = ch_rd_dat[i*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Output mux, pop strobe and next-state; rst masks every strobe at once.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        ch_rd_ena = '0;
        busy      = 1'b0;
        out_dat   = head_dat[gnt_q];
        out_ch    = gnt_q;
        hs        = 1'b0;
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        bcnt_d    = bcnt_q;

        if (!rst && state_q == S_BURST) begin
            busy             = 1'b1;
            out_valid        = ~gnt_empty;
            out_last         = out_valid & (bcnt_q == BC_LAST);
            hs               = out_valid & out_ready;
            ch_rd_ena[gnt_q] = hs;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_idx;
                    rr_ptr_d = pick_idx;
                    bcnt_d   = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (gnt_empty) begin
                    // Truncated burst: the granted FIFO ran dry.
                    state_d = S_IDLE;
                end else if (hs) begin
                    if (bcnt_q == BC_LAST) begin
                        state_d = S_IDLE;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= CH_W'(NUM_CH - 1);
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            bcnt_q   <= bcnt_d;
        end
    end

`ifdef DRAIN_ARB_STATS_EN
    logic [31:0] stat_q [NUM_CH];

    // Per-channel accepted-word counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        // NOTE: this array is a handful of flops, not a RAM, so every entry is reset and cleared explicitly.
        if (rst || stat_clr) begin
            for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
        end else if (hs) begin
            stat_q[gnt_q] <= stat_q[gnt_q] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        assign stat_words[i*32 +: 32] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Self-checking bench for fifo_drain_arbiter (NUM_CH=4, DATA_WIDTH=16,
// MAX_BURST=8). Behavioural FWFT FIFOs feed the DUT; each scenario pushes the
// words it expects, in order, to a scoreboard that is popped on handshakes.
module tb_fifo_drain_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DW        = 16;
    localparam int MAX_BURST = 8;
    localparam int CH_W      = 2;

    typedef struct {
        logic [DW-1:0]   dat;
        logic [CH_W-1:0] ch;
        logic            last;
        logic            first;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_rd_empty;
    logic [NUM_CH*DW-1:0] ch_rd_dat;
    logic [NUM_CH-1:0]    ch_rd_ena;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_dat;
    logic [CH_W-1:0]      out_ch;
    logic                 out_last;
    logic                 busy;
`ifdef DRAIN_ARB_STATS_EN
    logic                 stat_clr;
    logic [NUM_CH*32-1:0] stat_words;
`endif

    logic [DW-1:0]     fq [NUM_CH][$];
    exp_t              sb [$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                ready_mode = 0;
    int                n_pops   = 0;
    int                n_acc    = 0;
    logic [NUM_CH-1:0] pop_mask;
    logic              prev_busy, prev_valid, prev_ready;
    logic [3:0]        ready_pat = 4'b1001;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_rd_empty (ch_rd_empty),
        .ch_rd_dat   (ch_rd_dat),
        .ch_rd_ena   (ch_rd_ena),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dat     (out_dat),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .busy        (busy)
`ifdef DRAIN_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_words  (stat_words)
`endif
    );

    function automatic logic [DW-1:0] dat_of(input int ch, input int k);
        return DW'((ch << 12) | k);
    endfunction

    task automatic refresh_inputs();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rd_empty[i] = (fq[i].size() == 0);
            ch_rd_dat[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic fill(input int ch, input int k0, input int n);
        for (int j = 0; j < n; j++) fq[ch].push_back(dat_of(ch, k0 + j));
    endtask

    task automatic expect_burst(input int ch, input int k0, input int n, input bit full);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.dat   = dat_of(ch, k0 + j);
            e.ch    = CH_W'(ch);
            e.last  = full && (j == n - 1);
            e.first = (j == 0);
            sb.push_back(e);
        end
    endtask

    // Compare the DUT outputs of the current cycle against the scoreboard head.
    task automatic observe();
        exp_t              e;
        logic              hs;
        logic              have_e;
        logic [NUM_CH-1:0] exp_ena;
        pop_mask = '0;
        have_e   = 1'b0;
        if (rst) begin
            n_checks++;
            if (ch_rd_ena !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_force: ena=%b valid=%b busy=%b last=%b, required all 0",
                         ch_rd_ena, out_valid, busy, out_last);
            end
        end else begin
            hs = out_valid && out_ready;
            if (prev_valid && !prev_ready) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_valid: valid=%b, required 1 after a stalled word", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: dat=%h ch=%0d with empty scoreboard", out_dat, out_ch);
                end else begin
                    e      = sb[0];
                    have_e = 1'b1;
                    if (out_dat !== e.dat || out_ch !== e.ch || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL word: got dat=%h ch=%0d last=%b, required dat=%h ch=%0d last=%b",
                                 out_dat, out_ch, out_last, e.dat, e.ch, e.last);
                    end
                    if (e.first && !(prev_valid && !prev_ready)) begin
                        n_checks++;
                        if (prev_busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL bubble: busy before grant start=%b, required 0", prev_busy);
                        end
                    end
                    if (hs) void'(sb.pop_front());
                end
            end else begin
                n_checks++;
                if (out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL last_idle: last=%b while valid=0, required 0", out_last);
                end
            end
            exp_ena = '0;
            if (hs && have_e) exp_ena[e.ch] = 1'b1;
            n_checks++;
            if (ch_rd_ena !== exp_ena) begin
                n_fail++;
                $display("FAIL ena: got %b, required %b", ch_rd_ena, exp_ena);
            end
            if (hs) n_acc++;
            pop_mask = ch_rd_ena;
        end
        prev_busy  = busy;
        prev_valid = out_valid;
        prev_ready = out_ready;
    endtask

    // One clock: check at the falling edge, then apply pops and new inputs after the rising edge.
    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop_mask[i]) begin
                n_checks++;
                if (fq[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_empty: channel %0d popped while empty", i);
                end else begin
                    void'(fq[i].pop_front());
                    n_pops++;
                end
            end
        end
        refresh_inputs();
        cyc++;
        out_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
        sb.delete();
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < max_cycles) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= max_cycles) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, busy=%b after %0d cycles",
                     sb.size(), busy, n);
        end
    endtask

    task automatic check_fifos_empty(input string name);
        for (int i = 0; i < NUM_CH; i++) begin
            n_checks++;
            if (fq[i].size() != 0) begin
                n_fail++;
                $display("FAIL %s: channel %0d holds %0d words, required 0", name, i, fq[i].size());
            end
        end
    endtask

    task automatic test_reset();
        fill(0, 0, 3);
        fill(2, 0, 3);
        refresh_inputs();
        do_reset(3);
        for (int i = 0; i < NUM_CH; i++) fq[i].delete();
        refresh_inputs();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_single_channel();
        fill(2, 0, 3);
        refresh_inputs();
        do_reset(2);
        n_acc = 0;
        expect_burst(2, 0, 3, 1'b0);
        step();
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL first_grant: busy=%b valid=%b ch=%0d, required 1 1 2", busy, out_valid, out_ch);
        end
        drain(50);
        n_checks++;
        if (n_acc != 3) begin
            n_fail++;
            $display("FAIL single_count: accepted %0d, required 3", n_acc);
        end
        check_fifos_empty("single_left");
    endtask

    task automatic test_full_bursts();
        do_reset(2);
        n_acc = 0;
        fill(0, 0, 20);
        fill(1, 0, 20);
        refresh_inputs();
        expect_burst(0, 0, 8, 1'b1);
        expect_burst(1, 0, 8, 1'b1);
        expect_burst(0, 8, 8, 1'b1);
        expect_burst(1, 8, 8, 1'b1);
        expect_burst(0, 16, 4, 1'b0);
        expect_burst(1, 16, 4, 1'b0);
        drain(400);
        n_checks++;
        if (n_acc != 40) begin
            n_fail++;
            $display("FAIL full_count: accepted %0d, required 40", n_acc);
        end
        check_fifos_empty("full_left");
    endtask

    task automatic test_round_robin();
        do_reset(2);
        n_acc = 0;
        for (int c = 0; c < NUM_CH; c++) fill(c, 0, 16);
        refresh_inputs();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++) expect_burst(c, r * 8, 8, 1'b1);
        drain(400);
        n_checks++;
        if (n_acc != 64) begin
            n_fail++;
            $display("FAIL rr_count: accepted %0d, required 64", n_acc);
        end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        n_acc  = 0;
        n_pops = 0;
        ready_mode = 1;
        fill(1, 0, 10);
        refresh_inputs();
        expect_burst(1, 0, 8, 1'b1);
        expect_burst(1, 8, 2, 1'b0);
        drain(300);
        ready_mode = 0;
        out_ready  = 1'b1;
        n_checks++;
        if (n_pops != n_acc || n_acc != 10) begin
            n_fail++;
            $display("FAIL bp_count: pops=%0d accepted=%0d, required 10 10", n_pops, n_acc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_reset(2);
        n_acc = 0;
        fill(1, 0, 6);
        refresh_inputs();
        expect_burst(1, 0, 2, 1'b0);
        n = 0;
        while (n_acc < 2 && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (n_acc < 2) begin
            n_fail++;
            $display("FAIL mid_timeout: accepted %0d, required 2", n_acc);
        end
        // Word 3 of the ch1 burst is now at the head; other channels join.
        fill(0, 0, 2);
        fill(3, 0, 2);
        refresh_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        expect_burst(0, 0, 2, 1'b0);
        expect_burst(1, 2, 4, 1'b0);
        expect_burst(3, 0, 2, 1'b0);
        drain(200);
        check_fifos_empty("mid_left");
    endtask

`ifdef DRAIN_ARB_STATS_EN
    task automatic test_stats();
        logic [31:0] exp_cnt;
        int          acc0;
        do_reset(2);
        n_acc = 0;
        fill(3, 0, 5);
        refresh_inputs();
        expect_burst(3, 0, 5, 1'b0);
        drain(100);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_cnt = (i == 3) ? 32'd5 : 32'd0;
            n_checks++;
            if (stat_words[i*32 +: 32] !== exp_cnt) begin
                n_fail++;
                $display("FAIL stat_pre: ch%0d count=%0d, required %0d", i, stat_words[i*32 +: 32], exp_cnt);
            end
        end
        fill(0, 0, 3);
        refresh_inputs();
        expect_burst(0, 0, 3, 1'b0);
        step();
        acc0 = n_acc;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        n_checks++;
        if (n_acc != acc0 + 1) begin
            n_fail++;
            $display("FAIL stat_clr_hs: %0d handshakes in clear cycle, required 1", n_acc - acc0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n_checks++;
            if (stat_words[i*32 +: 32] !== 32'd0) begin
                n_fail++;
                $display("FAIL stat_clr: ch%0d count=%0d, required 0", i, stat_words[i*32 +: 32]);
            end
        end
        drain(100);
        n_checks++;
        if (stat_words[31:0] !== 32'd2) begin
            n_fail++;
            $display("FAIL stat_post: ch0 count=%0d, required 2", stat_words[31:0]);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b1;
        ch_rd_empty = '1;
        ch_rd_dat  = '0;
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
`ifdef DRAIN_ARB_STATS_EN
        stat_clr   = 1'b0;
`endif
        refresh_inputs();
        test_reset();
        test_single_channel();
        test_full_bursts();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
`ifdef DRAIN_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
